// File: rtl/keys_irq_pkg.sv
// Shared definitions for keys_irq_master: FSM state encoding, PIO register map
// and timestamp width.
package keys_irq_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRead,
        StSample,
        StClear,
        StPush
    } state_e;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    localparam int unsigned TS_WIDTH = 16;

endpackage

// File: rtl/keys_evt_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module keys_evt_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FullCount);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/keys_irq_master.sv
// Hardware servicing of an edge-capturing key PIO: mask setup, capture read,
// write-clear and event queueing. Optional timestamps: KEYS_IRQ_MASTER_TIMESTAMP_EN.
module keys_irq_master
    import keys_irq_pkg::*;
#(
    parameter int unsigned          KEY_WIDTH     = 4,
    parameter int unsigned          FIFO_DEPTH    = 8,
    parameter logic [KEY_WIDTH-1:0] IRQ_MASK_INIT = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        evt_valid,
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
    output logic [KEY_WIDTH+TS_WIDTH-1:0] evt_data,
`else
    output logic [KEY_WIDTH-1:0]          evt_data,
`endif
    input  logic        evt_ready,
    output logic        evt_overflow,
    input  logic        overflow_clr
);

`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
    localparam int unsigned EVT_W = KEY_WIDTH + TS_WIDTH;
`else
    localparam int unsigned EVT_W = KEY_WIDTH;
`endif

    state_e               r_state;
    state_e               w_state_next;
    logic [KEY_WIDTH-1:0] r_cap;
    logic                 r_overflow;
    logic                 w_cs;
    logic                 w_write_n;
    logic [1:0]           w_addr;
    logic [31:0]          w_wdata;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [EVT_W-1:0]     w_push_data;
    logic                 w_unused_rdata;

    assign w_unused_rdata = ^avm_readdata[31:KEY_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StInit;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cs         = 1'b0;
        w_write_n    = 1'b1;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            StInit: begin
                w_cs         = 1'b1;
                w_write_n    = 1'b0;
                w_addr       = PIO_ADDR_MASK;
                w_wdata      = 32'(IRQ_MASK_INIT);
                w_state_next = StIdle;
            end
            StIdle: begin
                if (irq) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                w_cs         = 1'b1;
                w_addr       = PIO_ADDR_EDGE;
                w_state_next = StSample;
            end
            StSample: begin
                w_state_next = (|avm_readdata[KEY_WIDTH-1:0]) ? StClear : StIdle;
            end
            StClear: begin
                w_cs         = 1'b1;
                w_write_n    = 1'b0;
                w_addr       = PIO_ADDR_EDGE;
                w_wdata      = 32'(r_cap);
                w_state_next = StPush;
            end
            StPush: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StInit;
            end
        endcase
    end

    // The state register already holds INIT during reset; keep the bus idle
    // until reset is released so the mask write happens exactly once.
    assign avm_chipselect = w_cs && !reset;
    assign avm_write_n    = w_write_n || reset;
    assign avm_address    = reset ? 2'd0 : w_addr;
    assign avm_writedata  = reset ? 32'd0 : w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap <= '0;
        end else if (r_state == StSample) begin
            r_cap <= avm_readdata[KEY_WIDTH-1:0];
        end
    end

`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] r_tstamp;
    logic [TS_WIDTH-1:0] r_ts_cap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tstamp <= '0;
            r_ts_cap <= '0;
        end else begin
            r_tstamp <= r_tstamp + 1'b1;
            if (r_state == StRead) begin
                r_ts_cap <= r_tstamp;
            end
        end
    end

    assign w_push_data = {r_ts_cap, r_cap};
`else
    assign w_push_data = r_cap;
`endif

    assign w_push = (r_state == StPush);
    // A full FIFO is never empty, so a requested pop always frees a slot.
    assign w_drop = w_push && w_fifo_full && !evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign evt_overflow = r_overflow;
    assign evt_valid    = !w_fifo_empty;

    keys_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (evt_ready),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_data      (evt_data)
    );

endmodule

// File: tb/tb_keys_irq_master.sv
// Self-checking bench for keys_irq_master: PIO model, queue-based event model,
// directed and randomized services.
module tb_keys_irq_master;

    localparam int unsigned KW    = 4;
    localparam int unsigned DEPTH = 8;
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
    localparam int unsigned EW = KW + 16;
`else
    localparam int unsigned EW = KW;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          irq;
    logic [1:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata = '0;
    logic          evt_valid;
    logic [EW-1:0] evt_data;
    logic          evt_ready;
    logic          evt_overflow;
    logic          overflow_clr;

    always #5 clk = ~clk;

    keys_irq_master #(
        .KEY_WIDTH     (KW),
        .FIFO_DEPTH    (DEPTH),
        .IRQ_MASK_INIT (4'hF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .evt_valid      (evt_valid),
        .evt_data       (evt_data),
        .evt_ready      (evt_ready),
        .evt_overflow   (evt_overflow),
        .overflow_clr   (overflow_clr)
    );

    // PIO model: edge capture with write-one-to-clear, mask, registered reads.
    logic [KW-1:0] pio_edge = '0;
    logic [KW-1:0] pio_mask = '0;
    logic [KW-1:0] inj      = '0;

    assign irq = |(pio_edge & pio_mask);

`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
    logic [15:0] tb_cnt = '0;
    logic [15:0] ts_all[$];
    logic [15:0] exp_ts_q[$];
`endif

    always @(posedge clk) begin
        logic [KW-1:0] clr;
        clr = '0;
        if (avm_chipselect && !avm_write_n) begin
            if (avm_address == 2'd2) pio_mask <= avm_writedata[KW-1:0];
            if (avm_address == 2'd3) clr = avm_writedata[KW-1:0];
        end
        pio_edge     <= (pio_edge & ~clr) | inj;
        avm_readdata <= (avm_chipselect && avm_write_n && avm_address == 2'd3) ?
                        32'(pio_edge) : 32'h0;
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        if (avm_chipselect && avm_write_n && avm_address == 2'd3) ts_all.push_back(tb_cnt);
        tb_cnt <= reset ? 16'h0 : tb_cnt + 16'h1;
`endif
    end

    int            n_checks = 0;
    int            n_errors = 0;
    logic [KW-1:0] exp_q[$];
    logic          exp_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 into the cycle in which irq first shows the injected bits.
    task automatic inject(input logic [KW-1:0] k);
        inj = k;
        tick(1);
        inj = '0;
    endtask

    task automatic model_push(input logic [KW-1:0] k);
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        logic [15:0] ts;
        ts = ts_all.pop_front();
`endif
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(k);
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
            exp_ts_q.push_back(ts);
`endif
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic model_pop();
        void'(exp_q.pop_front());
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        void'(exp_ts_q.pop_front());
`endif
    endtask

    task automatic service(input logic [KW-1:0] k);
        inject(k);
        tick(6);
        model_push(k);
    endtask

    task automatic pop_check(input string tag);
        int t;
        t = 0;
        while (!evt_valid && t < 20) begin
            tick(1);
            t++;
        end
        chk({tag, "_valid"}, 64'(evt_valid), 64'(1));
        chk({tag, "_key"}, 64'(evt_data[KW-1:0]), 64'(exp_q[0]));
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        chk({tag, "_ts"}, 64'(evt_data[EW-1:KW]), 64'(exp_ts_q[0]));
`endif
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        model_pop();
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) pop_check(tag);
        chk({tag, "_empty"}, 64'(evt_valid), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [KW-1:0] k;
        logic [KW-1:0] k9;
        int            t;

        reset        = 1'b1;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick(3);
        chk("rst_cs", 64'(avm_chipselect), 64'(0));
        chk("rst_wn", 64'(avm_write_n), 64'(1));
        chk("rst_addr", 64'(avm_address), 64'(0));
        chk("rst_wd", 64'(avm_writedata), 64'(0));
        chk("rst_valid", 64'(evt_valid), 64'(0));
        chk("rst_data", 64'(evt_data), 64'(0));
        chk("rst_ovf", 64'(evt_overflow), 64'(0));

        // Mask write in the first cycle after release, idle afterwards.
        reset = 1'b0;
        #1;
        chk("init_cs", 64'(avm_chipselect), 64'(1));
        chk("init_wn", 64'(avm_write_n), 64'(0));
        chk("init_addr", 64'(avm_address), 64'(2));
        chk("init_wd", 64'(avm_writedata), 64'hF);
        tick(1);
        chk("idle_cs", 64'(avm_chipselect), 64'(0));
        chk("pio_mask", 64'(pio_mask), 64'hF);

        // Cycle-accurate service of capture 0101.
        inject(4'b0101);
        chk("lat_irq", 64'(irq), 64'(1));
        tick(1);
        chk("lat_read", 64'({avm_chipselect, avm_write_n, avm_address}), 64'b1111);
        tick(1);
        chk("lat_sample_cs", 64'(avm_chipselect), 64'(0));
        tick(1);
        chk("lat_clear", 64'({avm_chipselect, avm_write_n, avm_address}), 64'b1011);
        chk("lat_clear_wd", 64'(avm_writedata), 64'h5);
        tick(1);
        chk("lat_irq_drop", 64'(irq), 64'(0));
        chk("lat_push_valid", 64'(evt_valid), 64'(0));
        tick(1);
        chk("lat_valid", 64'(evt_valid), 64'(1));
        chk("lat_data", 64'(evt_data[KW-1:0]), 64'h5);
        model_push(4'b0101);
        pop_check("lat_pop");

        // Key 1 edge lands after the capture read: only 0101 is cleared.
        inject(4'b0101);
        tick(1);
        inj = 4'b0010;
        tick(1);
        inj = '0;
        tick(2);
        chk("mid_irq_reraise", 64'(irq), 64'(1));
        tick(8);
        model_push(4'b0101);
        model_push(4'b0010);
        chk("mid_pio_clear", 64'(pio_edge), 64'(0));
        pop_check("mid_first");
        pop_check("mid_second");

        // Nine events with no consumer: eight queue, one is dropped.
        for (int i = 0; i < 9; i++) begin
            k = '0;
            k[i % 4] = 1'b1;
            service(k);
            chk("ovf_pio_clear", 64'(pio_edge), 64'(0));
        end
        chk("ovf_flag", 64'(evt_overflow), 64'(exp_ovf));
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clr", 64'(evt_overflow), 64'(0));
        drain("ovf_drain");

        // Full FIFO with a pop in the PUSH cycle: nothing dropped.
        for (int i = 0; i < DEPTH; i++) service(KW'($urandom_range(15, 1)));
        k9 = KW'($urandom_range(15, 1));
        inject(k9);
        tick(4);
        chk("fp_head", 64'(evt_data[KW-1:0]), 64'(exp_q[0]));
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        model_pop();
        model_push(k9);
        chk("fp_no_ovf", 64'(evt_overflow), 64'(0));
        drain("fp_drain");

        // Randomized services with random consumer activity.
        for (int i = 0; i < 24; i++) begin
            service(KW'($urandom_range(15, 1)));
            if ($urandom_range(1, 0) == 1) pop_check("rnd_pop");
        end
        chk("rnd_ovf", 64'(evt_overflow), 64'(exp_ovf));
        drain("rnd_drain");
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;

        // Reset during READ aborts; the uncleared capture is serviced again.
        inject(4'b1010);
        tick(1);
        reset = 1'b1;
        tick(1);
        chk("abort_bus_idle", 64'({avm_chipselect, avm_write_n}), 64'b01);
        exp_q.delete();
`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        ts_all.delete();
        exp_ts_q.delete();
`endif
        reset = 1'b0;
        #1;
        chk("abort_init_write", 64'({avm_chipselect, avm_write_n, avm_address}), 64'b1010);
        tick(8);
        model_push(4'b1010);
        chk("abort_pio_clear", 64'(pio_edge), 64'(0));
        pop_check("abort_pop");

`ifdef KEYS_IRQ_MASTER_TIMESTAMP_EN
        // Event issued so READ falls at count 0x0105, then across the wrap.
        t = 0;
        while (tb_cnt != 16'h0103 && t < 70000) begin
            tick(1);
            t++;
        end
        chk("ts_wait_0103", 64'(tb_cnt), 64'h0103);
        service(4'b0100);
        chk("ts_read_0105", 64'(exp_ts_q[0]), 64'h0105);
        pop_check("ts_0105");
        t = 0;
        while (tb_cnt != 16'hFFFE && t < 70000) begin
            tick(1);
            t++;
        end
        chk("ts_wait_fffe", 64'(tb_cnt), 64'hFFFE);
        service(4'b0001);
        chk("ts_read_wrap", 64'(exp_ts_q[0]), 64'h0000);
        pop_check("ts_wrap");
`else
        t = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
